// File: rtl/fetch_control.sv
// Fetch/decode/execute sequencer for a small RV64 subset (ld, sd, addi, add, sub).
// Fetches through a req/ack instruction port, decodes into datapath selects,
// and pulses one write enable per instruction.
module fetch_control #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  output logic        IM_REQ,
  output logic [63:0] IM_ADDR,
  input  logic        IM_ACK,
  input  logic [31:0] IM_DATA,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [11:0] immediate,
  output logic        sub,
  output logic        WE_RF,
  output logic        WE_MEM,
  output logic        RF_din_sel,
  output logic        ULA_din2_sel,
  output logic [63:0] PC,
  output logic        ILLEGAL
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, TRAP} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] ir;
  logic        started;
  logic        we_rf_q;
  logic        we_mem_q;
  logic        fetch_take;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        dec_legal;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [11:0] dec_imm;
  logic        dec_sub;
  logic        dec_rf_sel;
  logic        dec_ula_sel;
  logic        dec_we_rf;
  logic        dec_we_mem;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  // Requests only after the first enabled edge out of reset, so reset forces IM_REQ low at once.
  assign IM_REQ     = (state == FETCH) && EN && started;
  assign IM_ADDR    = PC;
  assign fetch_take = IM_REQ && IM_ACK;
  assign WE_RF      = (state == EXEC) && we_rf_q;
  assign WE_MEM     = (state == EXEC) && we_mem_q;
  assign ILLEGAL    = (state == TRAP);

  // Instruction decoder: anything outside the four supported encodings is illegal.
  always_comb begin
    dec_legal   = 1'b0;
    dec_rs1     = ir[19:15];
    dec_rs2     = ir[24:20];
    dec_rd      = ir[11:7];
    dec_imm     = ir[31:20];
    dec_sub     = 1'b0;
    dec_rf_sel  = 1'b0;
    dec_ula_sel = 1'b0;
    dec_we_rf   = 1'b0;
    dec_we_mem  = 1'b0;
    case (opcode)
      7'b0000011: begin
        if (funct3 == 3'b011) begin
          dec_legal   = 1'b1;
          dec_ula_sel = 1'b1;
          dec_we_rf   = (ir[11:7] != 5'd0);
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b011) begin
          dec_legal   = 1'b1;
          dec_imm     = {ir[31:25], ir[11:7]};
          dec_rd      = 5'd0;
          dec_ula_sel = 1'b1;
          dec_we_mem  = 1'b1;
        end
      end
      7'b0010011: begin
        if (funct3 == 3'b000) begin
          dec_legal   = 1'b1;
          dec_rf_sel  = 1'b1;
          dec_ula_sel = 1'b1;
          dec_we_rf   = (ir[11:7] != 5'd0);
        end
      end
      7'b0110011: begin
        if ((funct3 == 3'b000) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) begin
          dec_legal  = 1'b1;
          dec_imm    = 12'd0;
          dec_rf_sel = 1'b1;
          dec_sub    = ir[30];
          dec_we_rf  = (ir[11:7] != 5'd0);
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state logic for the fetch/decode/execute sequence.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (fetch_take) state_next = DECODE;
      DECODE:  state_next = dec_legal ? EXEC : TRAP;
      EXEC:    state_next = FETCH;
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= FETCH;
    else        state <= state_next;
  end

  // PC, instruction register and decoded fields, held stable from EXEC until the next decode.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PC           <= RESET_PC;
      ir           <= 32'd0;
      started      <= 1'b0;
      rs1          <= 5'd0;
      rs2          <= 5'd0;
      rd           <= 5'd0;
      immediate    <= 12'd0;
      sub          <= 1'b0;
      RF_din_sel   <= 1'b0;
      ULA_din2_sel <= 1'b0;
      we_rf_q      <= 1'b0;
      we_mem_q     <= 1'b0;
    end else begin
      started <= started | EN;
      if (fetch_take) ir <= IM_DATA;
      if ((state == DECODE) && dec_legal) begin
        rs1          <= dec_rs1;
        rs2          <= dec_rs2;
        rd           <= dec_rd;
        immediate    <= dec_imm;
        sub          <= dec_sub;
        RF_din_sel   <= dec_rf_sel;
        ULA_din2_sel <= dec_ula_sel;
        we_rf_q      <= dec_we_rf;
        we_mem_q     <= dec_we_mem;
      end
      if (state == EXEC) PC <= PC + 64'd4;
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: stimulus pushes expected execute-cycle
// snapshots, a negedge monitor pops and compares on every write-enable pulse.
module tb_fetch_control;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic        IM_REQ;
  logic [63:0] IM_ADDR;
  logic        IM_ACK;
  logic [31:0] IM_DATA;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] immediate;
  logic        sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel;
  logic [63:0] PC;
  logic        ILLEGAL;

  logic        wrapReq;
  logic [63:0] wrapAddr;
  logic [4:0]  wrapRs1, wrapRs2, wrapRd;
  logic [11:0] wrapImm;
  logic        wrapSub, wrapWeRf, wrapWeMem, wrapRfSel, wrapUlaSel;
  logic [63:0] wrapPc;
  logic        wrapIllegal;

  int checks = 0;
  int errors = 0;
  logic [95:0] expQ[$];

  fetch_control #(.RESET_PC(64'h0)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR),
    .IM_ACK(IM_ACK), .IM_DATA(IM_DATA), .rs1(rs1), .rs2(rs2), .rd(rd),
    .immediate(immediate), .sub(sub), .WE_RF(WE_RF), .WE_MEM(WE_MEM),
    .RF_din_sel(RF_din_sel), .ULA_din2_sel(ULA_din2_sel), .PC(PC), .ILLEGAL(ILLEGAL)
  );

  fetch_control #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dutWrap (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .IM_REQ(wrapReq), .IM_ADDR(wrapAddr),
    .IM_ACK(IM_ACK), .IM_DATA(IM_DATA), .rs1(wrapRs1), .rs2(wrapRs2), .rd(wrapRd),
    .immediate(wrapImm), .sub(wrapSub), .WE_RF(wrapWeRf), .WE_MEM(wrapWeMem),
    .RF_din_sel(wrapRfSel), .ULA_din2_sel(wrapUlaSel), .PC(wrapPc), .ILLEGAL(wrapIllegal)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [95:0] mkVec(input logic [4:0] vRd, input logic [4:0] vRs1,
                                        input logic [4:0] vRs2, input logic [11:0] vImm,
                                        input logic vSub, input logic vRf, input logic vUla,
                                        input logic vWeRf, input logic vWeMem, input logic [63:0] vPc);
    return {vRd, vRs1, vRs2, vImm, vSub, vRf, vUla, vWeRf, vWeMem, vPc};
  endfunction

  function automatic logic [95:0] dutVec();
    return {rd, rs1, rs2, immediate, sub, RF_din_sel, ULA_din2_sel, WE_RF, WE_MEM, PC};
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every write-enable pulse is matched against the oldest expected snapshot.
  always @(negedge CLK) begin
    if (RST_N && (WE_RF || WE_MEM)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_we", dutVec(), 96'd0);
      end else begin
        checkOutput("exec_snapshot", dutVec(), expQ.pop_front());
      end
    end
  end

  task automatic waitReq(output logic seen);
    int n;
    n = 0;
    while (!IM_REQ && n < 20) begin
      @(negedge CLK);
      n++;
    end
    seen = IM_REQ;
    if (!seen) checkOutput("req_timeout", 96'd0, 96'd1);
  endtask

  // One full instruction: optional ack wait, optional EN drop during DECODE.
  task automatic applyStimulus(input logic [31:0] word, input int waits, input logic pulse,
                               input logic [95:0] expVec, input logic [63:0] pcNow,
                               input logic dropEn);
    logic seen;
    logic holdOk;
    waitReq(seen);
    if (!seen) return;
    holdOk = 1'b1;
    for (int i = 0; i < waits; i++) begin
      if (!IM_REQ || IM_ADDR !== pcNow || WE_RF || WE_MEM) holdOk = 1'b0;
      @(negedge CLK);
    end
    checkOutput("fetch_hold", {holdOk, IM_REQ, IM_ADDR}, {1'b1, 1'b1, pcNow});
    if (pulse) expQ.push_back(expVec);
    IM_ACK  = 1'b1;
    IM_DATA = word;
    @(posedge CLK);
    @(negedge CLK);
    IM_ACK = 1'b0;
    checkOutput("decode_idle", {IM_REQ, WE_RF, WE_MEM}, 3'b000);
    if (dropEn) EN = 1'b0;
    @(negedge CLK);
    checkOutput("exec_we", WE_RF | WE_MEM, pulse);
    @(posedge CLK);
    #1;
    checkOutput("pc_next", PC, pcNow + 64'd4);
    @(negedge CLK);
    if (dropEn) begin
      checkOutput("en_hold", IM_REQ, 1'b0);
      EN = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    logic ok;
    RST_N   = 1'b0;
    EN      = 1'b1;
    IM_ACK  = 1'b0;
    IM_DATA = 32'd0;
    repeat (2) @(negedge CLK);

    checkOutput("reset_state", {IM_REQ, WE_RF, WE_MEM, ILLEGAL, rd, rs1, rs2, immediate, sub, RF_din_sel, ULA_din2_sel, PC},
                {4'b0000, 5'd0, 5'd0, 5'd0, 12'd0, 3'b000, 64'd0});
    checkOutput("reset_pc_wrap", wrapPc, 64'hFFFF_FFFF_FFFF_FFFC);

    RST_N = 1'b1;
    checkOutput("req_before_edge", IM_REQ, 1'b0);

    applyStimulus(32'h00700293, 0, 1'b1, mkVec(5'd5, 5'd0, 5'd7, 12'h007, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0), 64'd0, 1'b0);
    checkOutput("pc_wraps", wrapPc, 64'd0);
    applyStimulus(32'h402081B3, 0, 1'b1, mkVec(5'd3, 5'd1, 5'd2, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd4), 64'd4, 1'b0);
    applyStimulus(32'h0030B423, 0, 1'b1, mkVec(5'd0, 5'd1, 5'd3, 12'h008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'd8), 64'd8, 1'b1);

    EN      = 1'b0;
    IM_ACK  = 1'b1;
    IM_DATA = 32'hFFFF_FFFF;
    ok = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (IM_REQ || PC !== 64'd12 || ILLEGAL) ok = 1'b0;
    end
    checkOutput("ack_ignored_en_low", ok, 1'b1);
    IM_ACK = 1'b0;
    EN     = 1'b1;

    applyStimulus(32'h00100313, 5, 1'b1, mkVec(5'd6, 5'd0, 5'd1, 12'h001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd12), 64'd12, 1'b0);
    applyStimulus(32'h0000B003, 0, 1'b0, 96'd0, 64'd16, 1'b0);

    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    applyStimulus(32'h00700293, 0, 1'b1, mkVec(5'd5, 5'd0, 5'd7, 12'h007, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0), 64'd0, 1'b0);
    applyStimulus(32'h00700293, 0, 1'b1, mkVec(5'd5, 5'd0, 5'd7, 12'h007, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd4), 64'd4, 1'b0);
    waitReq(seen);
    IM_ACK  = 1'b1;
    IM_DATA = 32'hFFFF_FFFF;
    @(posedge CLK);
    @(negedge CLK);
    ok = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (!ILLEGAL || PC !== 64'd8 || IM_REQ || WE_RF || WE_MEM) ok = 1'b0;
    end
    checkOutput("trap_hold", {ok, ILLEGAL, PC}, {1'b1, 1'b1, 64'd8});
    IM_ACK = 1'b0;
    RST_N  = 1'b0;
    #1;
    checkOutput("trap_reset_clear", {ILLEGAL, PC}, {1'b0, 64'd0});

    @(negedge CLK);
    RST_N = 1'b1;
    waitReq(seen);
    expQ.push_back(mkVec(5'd5, 5'd0, 5'd7, 12'h007, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0));
    IM_ACK  = 1'b1;
    IM_DATA = 32'h00700293;
    @(posedge CLK);
    @(negedge CLK);
    IM_ACK = 1'b0;
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("reset_mid_exec_we", {WE_RF, WE_MEM, PC}, {2'b00, 64'd0});
    @(posedge CLK);
    #1;
    checkOutput("reset_mid_exec_pc", PC, 64'd0);

    checkOutput("scoreboard_drain", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
